// File: rtl/spi_mem_formatter_if.sv
// Bundle of control handshake, RAM port-A bus and verify status for spi_mem_formatter.
// The master modport is the formatter's view; slave is the firmware/RAM side.
interface spi_mem_formatter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed;
  logic              verify_en;
  logic              busy;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [CNT_W-1:0]  err_count;
  logic [ADDR_W-1:0] err_first_addr;
  logic              err_flag;

  modport master (
    input  start, mode, seed, verify_en, mem_dout,
    output busy, done, mem_we, mem_addr, mem_din, err_count, err_first_addr, err_flag
  );

  modport slave (
    output start, mode, seed, verify_en, mem_dout,
    input  busy, done, mem_we, mem_addr, mem_din, err_count, err_first_addr, err_flag
  );
endinterface

// File: rtl/spi_mem_formatter.sv
// Fills an SPI buffer RAM with a selectable pattern and optionally reads it back,
// counting mismatches against a pipelined copy of the expected data.
module spi_mem_formatter #(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter int          RD_LAT    = 1,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
  input logic                 SysClk,
  input logic                 Reset,
  spi_mem_formatter_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] POLY      = DATA_W'(LFSR_POLY);
  localparam int                DRAIN_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, FILL, VERIFY, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [DATA_W-1:0]  seed_q;
  logic               verify_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  pat_q, pat_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               capture;
  logic               last;
  logic               pipe_vld  [RD_LAT];
  logic [ADDR_W-1:0]  pipe_addr [RD_LAT];
  logic [DATA_W-1:0]  pipe_exp  [RD_LAT];
  logic [CNT_W-1:0]   err_count_q;
  logic [ADDR_W-1:0]  err_first_q;
  logic               err_flag_q;

  function automatic logic [DATA_W-1:0] first_word(input logic [1:0] md,
                                                   input logic [DATA_W-1:0] sd);
    return (md == 2'd3 && sd == '0) ? DATA_W'(1) : sd;
  endfunction

  // Pattern for address a, given the word at a-1 (only the LFSR mode needs it).
  function automatic logic [DATA_W-1:0] next_word(input logic [1:0] md,
                                                  input logic [DATA_W-1:0] sd,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] prev);
    logic [DATA_W-1:0] w;
    w = sd;
    case (md)
      2'd1: w = sd + DATA_W'(a);
      2'd2: w = a[0] ? ~sd : sd;
      2'd3: begin
        w = prev >> 1;
        if (prev[0]) w = w ^ POLY;
      end
      default: w = sd;
    endcase
    return w;
  endfunction

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pat_d   = pat_q;
    we_d    = 1'b0;
    din_d   = '0;
    drain_d = drain_q;
    capture = 1'b0;
    last    = (addr_q == LAST_ADDR);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = FILL;
          addr_d  = '0;
          pat_d   = first_word(bus.mode, bus.seed);
          we_d    = 1'b1;
          din_d   = pat_d;
        end
      end
      FILL: begin
        if (last) begin
          addr_d  = '0;
          pat_d   = first_word(mode_q, seed_q);
          state_d = verify_q ? VERIFY : DONE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          pat_d  = next_word(mode_q, seed_q, addr_d, pat_q);
          we_d   = 1'b1;
          din_d  = pat_d;
        end
      end
      VERIFY: begin
        if (last) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(RD_LAT - 1);
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          pat_d  = next_word(mode_q, seed_q, addr_d, pat_q);
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The expected pipe mirrors the RAM read latency so each returned word meets its own address.
  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      mode_q      <= '0;
      seed_q      <= '0;
      verify_q    <= 1'b0;
      addr_q      <= '0;
      pat_q       <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
      drain_q     <= '0;
      err_count_q <= '0;
      err_first_q <= '0;
      err_flag_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
        pipe_exp[i]  <= '0;
      end
    end else begin
      addr_q  <= addr_d;
      pat_q   <= pat_d;
      we_q    <= we_d;
      din_q   <= din_d;
      drain_q <= drain_d;
      if (capture) begin
        mode_q   <= bus.mode;
        seed_q   <= bus.seed;
        verify_q <= bus.verify_en;
      end
      pipe_vld[0]  <= (state_q == VERIFY);
      pipe_addr[0] <= addr_q;
      pipe_exp[0]  <= pat_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
      end
      if (capture) begin
        err_count_q <= '0;
        err_first_q <= '0;
        err_flag_q  <= 1'b0;
      end else if (pipe_vld[RD_LAT-1] && bus.mem_dout != pipe_exp[RD_LAT-1]) begin
        if (err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
        if (!err_flag_q) begin
          err_first_q <= pipe_addr[RD_LAT-1];
          err_flag_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.busy           = (state_q == FILL) || (state_q == VERIFY) || (state_q == DRAIN);
  assign bus.done           = (state_q == DONE);
  assign bus.mem_we         = we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_din        = din_q;
  assign bus.err_count      = err_count_q;
  assign bus.err_first_addr = err_first_q;
  assign bus.err_flag       = err_flag_q;

endmodule

// File: tb/tb_spi_mem_formatter.sv
// Directed bench for spi_mem_formatter: a small DUT (DEPTH 16, RD_LAT 2, CNT_W 2)
// and a large DUT (DEPTH 1024, RD_LAT 1, CNT_W 16), each with its own RAM model.
module tb_spi_mem_formatter;

  logic        SysClk;
  logic        Reset;
  logic        sel;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        verify_en;

  int checks   = 0;
  int failures = 0;

  spi_mem_formatter_if #(.ADDR_W(10), .DATA_W(32), .CNT_W(2))  sml_if ();
  spi_mem_formatter_if #(.ADDR_W(10), .DATA_W(32), .CNT_W(16)) big_if ();

  spi_mem_formatter #(.ADDR_W(10), .DATA_W(32), .DEPTH(16), .RD_LAT(2), .CNT_W(2),
                      .LFSR_POLY(32'h80200003)) dut_sml (
    .SysClk(SysClk), .Reset(Reset), .bus(sml_if));

  spi_mem_formatter #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .RD_LAT(1), .CNT_W(16),
                      .LFSR_POLY(32'h80200003)) dut_big (
    .SysClk(SysClk), .Reset(Reset), .bus(big_if));

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  assign sml_if.start     = start & ~sel;
  assign big_if.start     = start & sel;
  assign sml_if.mode      = mode;
  assign big_if.mode      = mode;
  assign sml_if.seed      = seed;
  assign big_if.seed      = seed;
  assign sml_if.verify_en = verify_en;
  assign big_if.verify_en = verify_en;

  // RAM models; read data may be corrupted on the way out to provoke verify mismatches.
  logic [31:0]   sml_mem [16];
  logic [31:0]   sml_d1;
  logic          sml_corrupt_all;
  logic [31:0]   big_mem [1024];
  logic [1023:0] big_corrupt;

  always @(posedge SysClk) begin
    if (sml_if.mem_we) sml_mem[sml_if.mem_addr[3:0]] <= sml_if.mem_din;
    sml_d1          <= sml_mem[sml_if.mem_addr[3:0]] ^ {31'b0, sml_corrupt_all};
    sml_if.mem_dout <= sml_d1;
  end

  always @(posedge SysClk) begin
    if (big_if.mem_we) big_mem[big_if.mem_addr] <= big_if.mem_din;
    big_if.mem_dout <= big_mem[big_if.mem_addr] ^ {31'b0, big_corrupt[big_if.mem_addr]};
  end

  logic        obs_we, obs_busy, obs_done, obs_err_flag;
  logic [9:0]  obs_addr, obs_err_first;
  logic [31:0] obs_din;
  logic [15:0] obs_err_count;

  always_comb begin
    obs_we        = sel ? big_if.mem_we         : sml_if.mem_we;
    obs_busy      = sel ? big_if.busy           : sml_if.busy;
    obs_done      = sel ? big_if.done           : sml_if.done;
    obs_err_flag  = sel ? big_if.err_flag       : sml_if.err_flag;
    obs_addr      = sel ? big_if.mem_addr       : sml_if.mem_addr;
    obs_err_first = sel ? big_if.err_first_addr : sml_if.err_first_addr;
    obs_din       = sel ? big_if.mem_din        : sml_if.mem_din;
    obs_err_count = sel ? big_if.err_count      : 16'(sml_if.err_count);
  end

  int          n_wr, bad_wr, done_cyc, first_wr, busy_gap;
  logic        done_after, busy_after, busy_after2, errf_c1;
  logic [15:0] err_c1;
  logic [31:0] wdata [1024];

  function automatic logic [31:0] tb_word(input logic [1:0] md, input logic [31:0] sd,
                                          input int idx, input logic [31:0] prev);
    logic [31:0] w;
    w = sd;
    if (idx == 0) w = (md == 2'd3 && sd == 32'h0) ? 32'h1 : sd;
    else begin
      case (md)
        2'd0: w = sd;
        2'd1: w = sd + 32'(idx);
        2'd2: w = (idx % 2 == 1) ? ~sd : sd;
        default: begin
          w = prev >> 1;
          if (prev[0]) w = w ^ 32'h80200003;
        end
      endcase
    end
    return w;
  endfunction

  // Runs one format operation on the selected DUT and records what the bus did.
  task automatic run_op(input logic [1:0] md, input logic [31:0] sd, input logic ve,
                        input int limit, input int pulse_cyc, input bit pulse_done);
    logic [31:0] exp_w;
    @(negedge SysClk);
    mode = md; seed = sd; verify_en = ve; start = 1'b1;
    @(posedge SysClk);
    n_wr = 0; bad_wr = 0; done_cyc = 0; first_wr = 0; busy_gap = 0;
    exp_w = tb_word(md, sd, 0, 32'h0);
    for (int c = 1; c <= limit; c++) begin
      @(negedge SysClk);
      if (c == pulse_cyc) begin
        start = 1'b1; mode = ~md; seed = ~sd; verify_en = ~ve;
      end else start = 1'b0;
      if (c == 1) begin
        err_c1  = obs_err_count;
        errf_c1 = obs_err_flag;
      end
      if (obs_we) begin
        if (n_wr == 0) first_wr = c;
        if (obs_addr !== 10'(n_wr) || obs_din !== exp_w) bad_wr++;
        if (n_wr < 1024) wdata[n_wr] = obs_din;
        n_wr++;
        exp_w = tb_word(md, sd, n_wr, exp_w);
      end
      if (obs_done) begin
        done_cyc = c;
        break;
      end
      if (!obs_busy) busy_gap++;
    end
    start = pulse_done;
    @(negedge SysClk);
    done_after = obs_done;
    busy_after = obs_busy;
    start = 1'b0;
    @(negedge SysClk);
    busy_after2 = obs_busy;
  endtask

  task automatic test_reset;
    Reset = 1'b0; start = 1'b0; sel = 1'b0; mode = 2'd0; seed = 32'h0; verify_en = 1'b0;
    sml_corrupt_all = 1'b0;
    big_corrupt = '0;
    repeat (3) @(negedge SysClk);
    checks++; if ({sml_if.busy, sml_if.done, sml_if.mem_we, sml_if.err_flag} !== 4'b0) begin
      failures++; $display("[TB] FAIL reset_sml_ctrl: got %b expected 0000",
        {sml_if.busy, sml_if.done, sml_if.mem_we, sml_if.err_flag}); end
    checks++; if ({big_if.busy, big_if.done, big_if.mem_we, big_if.err_flag} !== 4'b0) begin
      failures++; $display("[TB] FAIL reset_big_ctrl: got %b expected 0000",
        {big_if.busy, big_if.done, big_if.mem_we, big_if.err_flag}); end
    checks++; if ({big_if.mem_addr, big_if.mem_din, big_if.err_count, big_if.err_first_addr} !== 68'h0) begin
      failures++; $display("[TB] FAIL reset_big_data: got %h expected 0",
        {big_if.mem_addr, big_if.mem_din, big_if.err_count, big_if.err_first_addr}); end
    checks++; if ({sml_if.mem_addr, sml_if.mem_din, sml_if.err_count, sml_if.err_first_addr} !== 54'h0) begin
      failures++; $display("[TB] FAIL reset_sml_data: got %h expected 0",
        {sml_if.mem_addr, sml_if.mem_din, sml_if.err_count, sml_if.err_first_addr}); end
    Reset = 1'b1;
    @(negedge SysClk);
  endtask

  task automatic test_const_fill;
    sel = 1'b0;
    run_op(2'd0, 32'h5A6CC6A5, 1'b0, 60, 0, 1'b0);
    checks++; if (n_wr !== 16) begin failures++; $display("[TB] FAIL const_writes: got %0d expected 16", n_wr); end
    checks++; if (bad_wr !== 0) begin failures++; $display("[TB] FAIL const_data: got %0d bad writes expected 0", bad_wr); end
    checks++; if (wdata[15] !== 32'h5A6CC6A5) begin failures++; $display("[TB] FAIL const_word15: got %h expected 5A6CC6A5", wdata[15]); end
    checks++; if (first_wr !== 1) begin failures++; $display("[TB] FAIL const_first_write: got cycle %0d expected 1", first_wr); end
    checks++; if (done_cyc !== 17) begin failures++; $display("[TB] FAIL const_done_cycle: got %0d expected 17", done_cyc); end
    checks++; if (busy_gap !== 0) begin failures++; $display("[TB] FAIL const_busy: got %0d idle cycles expected 0", busy_gap); end
    checks++; if ({done_after, busy_after} !== 2'b00) begin failures++; $display("[TB] FAIL const_done_pulse: got %b expected 00", {done_after, busy_after}); end
  endtask

  task automatic test_lfsr_start_ignored;
    sel = 1'b0;
    run_op(2'd3, 32'h0, 1'b0, 60, 5, 1'b1);
    checks++; if (wdata[0] !== 32'h00000001) begin failures++; $display("[TB] FAIL lfsr_word0: got %h expected 00000001", wdata[0]); end
    checks++; if (wdata[1] !== 32'h80200003) begin failures++; $display("[TB] FAIL lfsr_word1: got %h expected 80200003", wdata[1]); end
    checks++; if (wdata[2] !== 32'hC0300002) begin failures++; $display("[TB] FAIL lfsr_word2: got %h expected C0300002", wdata[2]); end
    checks++; if (n_wr !== 16 || bad_wr !== 0) begin failures++; $display("[TB] FAIL lfsr_writes: got %0d writes %0d bad expected 16 0", n_wr, bad_wr); end
    checks++; if (done_cyc !== 17) begin failures++; $display("[TB] FAIL lfsr_done_cycle: got %0d expected 17", done_cyc); end
    checks++; if ({busy_after, busy_after2} !== 2'b00) begin failures++; $display("[TB] FAIL start_in_done: got busy %b expected 00", {busy_after, busy_after2}); end
  endtask

  task automatic test_small_verify;
    sel = 1'b0;
    run_op(2'd1, 32'hCAFE0000, 1'b1, 80, 0, 1'b0);
    checks++; if (done_cyc !== 35) begin failures++; $display("[TB] FAIL sml_verify_done: got %0d expected 35", done_cyc); end
    checks++; if ({obs_err_count, obs_err_flag} !== 17'h0) begin failures++; $display("[TB] FAIL sml_verify_clean: got count %0d flag %b expected 0 0", obs_err_count, obs_err_flag); end
    checks++; if (n_wr !== 16 || bad_wr !== 0) begin failures++; $display("[TB] FAIL sml_verify_writes: got %0d writes %0d bad expected 16 0", n_wr, bad_wr); end
    sml_corrupt_all = 1'b1;
    run_op(2'd0, 32'h12345678, 1'b1, 80, 0, 1'b0);
    sml_corrupt_all = 1'b0;
    checks++; if (obs_err_count !== 16'd3) begin failures++; $display("[TB] FAIL saturate_count: got %0d expected 3", obs_err_count); end
    checks++; if (obs_err_first !== 10'd0 || obs_err_flag !== 1'b1) begin failures++; $display("[TB] FAIL saturate_first: got addr %0d flag %b expected 0 1", obs_err_first, obs_err_flag); end
    checks++; if (done_cyc !== 35) begin failures++; $display("[TB] FAIL saturate_done: got %0d expected 35", done_cyc); end
  endtask

  task automatic test_reset_midfill;
    bit   found;
    logic seen;
    sel = 1'b0;
    found = 1'b0;
    @(negedge SysClk);
    mode = 2'd1; seed = 32'h100; verify_en = 1'b0; start = 1'b1;
    @(posedge SysClk);
    @(negedge SysClk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (obs_we && obs_addr == 10'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge SysClk);
    end
    checks++; if (found !== 1'b1) begin failures++; $display("[TB] FAIL midfill_reach7: got %b expected 1", found); end
    Reset = 1'b0;
    #1;
    checks++; if ({obs_we, obs_busy, obs_done} !== 3'b000) begin failures++; $display("[TB] FAIL midfill_async: got %b expected 000", {obs_we, obs_busy, obs_done}); end
    seen = 1'b0;
    repeat (4) begin
      @(negedge SysClk);
      seen = seen | obs_we | obs_busy | obs_done;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL midfill_quiet: got %b expected 0", seen); end
    Reset = 1'b1;
    @(negedge SysClk);
    run_op(2'd1, 32'h100, 1'b0, 60, 0, 1'b0);
    checks++; if (first_wr !== 1 || n_wr !== 16 || bad_wr !== 0) begin failures++; $display("[TB] FAIL midfill_restart: got first %0d writes %0d bad %0d expected 1 16 0", first_wr, n_wr, bad_wr); end
    checks++; if (done_cyc !== 17) begin failures++; $display("[TB] FAIL midfill_done: got %0d expected 17", done_cyc); end
  endtask

  task automatic test_verify_clean;
    sel = 1'b1;
    run_op(2'd2, 32'hA5A5F00F, 1'b1, 2100, 0, 1'b0);
    checks++; if (done_cyc !== 2050) begin failures++; $display("[TB] FAIL verify_done: got %0d expected 2050", done_cyc); end
    checks++; if ({obs_err_count, obs_err_flag} !== 17'h0) begin failures++; $display("[TB] FAIL verify_clean: got count %0d flag %b expected 0 0", obs_err_count, obs_err_flag); end
    checks++; if (n_wr !== 1024 || bad_wr !== 0) begin failures++; $display("[TB] FAIL verify_writes: got %0d writes %0d bad expected 1024 0", n_wr, bad_wr); end
    checks++; if (wdata[1] !== 32'h5A5A0FF0) begin failures++; $display("[TB] FAIL alt_word1: got %h expected 5A5A0FF0", wdata[1]); end
    checks++; if (busy_gap !== 0) begin failures++; $display("[TB] FAIL verify_busy: got %0d idle cycles expected 0", busy_gap); end
  endtask

  task automatic test_verify_errors;
    sel = 1'b1;
    big_corrupt[5] = 1'b1;
    big_corrupt[9] = 1'b1;
    run_op(2'd2, 32'hA5A5F00F, 1'b1, 2100, 0, 1'b0);
    big_corrupt = '0;
    checks++; if (obs_err_count !== 16'd2) begin failures++; $display("[TB] FAIL err_count: got %0d expected 2", obs_err_count); end
    checks++; if (obs_err_first !== 10'd5) begin failures++; $display("[TB] FAIL err_first_addr: got %0d expected 5", obs_err_first); end
    checks++; if (obs_err_flag !== 1'b1) begin failures++; $display("[TB] FAIL err_flag: got %b expected 1", obs_err_flag); end
    checks++; if (done_cyc !== 2050) begin failures++; $display("[TB] FAIL err_done: got %0d expected 2050", done_cyc); end
  endtask

  task automatic test_incr_wrap;
    sel = 1'b1;
    run_op(2'd1, 32'hFFFFFFF0, 1'b0, 1100, 0, 1'b0);
    checks++; if ({err_c1, errf_c1} !== 17'h0) begin failures++; $display("[TB] FAIL err_cleared_on_start: got count %0d flag %b expected 0 0", err_c1, errf_c1); end
    checks++; if (wdata[15] !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL incr_addr00F: got %h expected FFFFFFFF", wdata[15]); end
    checks++; if (wdata[16] !== 32'h00000000) begin failures++; $display("[TB] FAIL incr_addr010: got %h expected 00000000", wdata[16]); end
    checks++; if (wdata[1023] !== 32'h000003EF) begin failures++; $display("[TB] FAIL incr_addr3FF: got %h expected 000003EF", wdata[1023]); end
    checks++; if (n_wr !== 1024 || bad_wr !== 0) begin failures++; $display("[TB] FAIL incr_writes: got %0d writes %0d bad expected 1024 0", n_wr, bad_wr); end
    checks++; if (done_cyc !== 1025) begin failures++; $display("[TB] FAIL incr_done: got %0d expected 1025", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_const_fill();
    test_lfsr_start_ignored();
    test_small_verify();
    test_reset_midfill();
    test_verify_clean();
    test_verify_errors();
    test_incr_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
